load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Sits between the MEM pipeline stage and the 64-byte, byte-addressed doubleword data memory. It accepts one load or store request at a time over a valid/ready handshake. Sub-word stores are done as a read-modify-write, because the memory writes only full 8-byte groups. Load data is sign- or zero-extended before it is returned as a registered response.

Parameters:
MEM_BYTES, 64, memory size in bytes; an access is legal only if addr <= MEM_BYTES-8

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 (size and sign)
req_addr  in  64  byte address
req_wdata  in  64  store data; low bytes are used
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts the response
resp_rdata  out  64  extended load data (0 for stores and errors)
resp_err  out  1  request rejected; memory untouched
memRead  out  1  memory read enable
memWrite  out  1  memory write enable (commits on posedge)
mem_address  out  64  memory byte address
mem_write_data  out  64  8-byte write group
mem_read_data  in  64  combinational memory read data

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid, resp_err, memRead, memWrite = 0; resp_rdata, mem_address, mem_write_data = 0.
- FSM states: IDLE, RD, WR, RESP. A request is accepted on a clock edge where req_valid && req_ready; opcode, address and data are registered at that edge.
- Transitions out of IDLE on accept:
  - Error request: go to RESP.
  - Load: go to RD.
  - Store with funct3=011 (sd): go to WR.
  - Other store: go to RD.
- RD: memRead=1, mem_address=addr. mem_read_data is captured at the edge leaving RD.
  - Load: go to RESP.
  - Store: go to WR.
- WR: memWrite=1 and mem_write_data=merged doubleword; the memory commits at the edge leaving WR. Then go to RESP.
  - sb: low 8 bits of wdata replace the captured byte 0.
  - sh: low 16 bits replace captured bytes 0–1.
  - sw: low 32 bits replace captured bytes 0–3.
  - sd: wdata is written as-is.
- RESP: resp_valid=1; resp_rdata, resp_err and all outputs are held stable. Return to IDLE on the edge where resp_ready=1.
- Latency from accept to resp_valid:
  - Load: 2 cycles.
  - sd: 2 cycles.
  - sb/sh/sw: 3 cycles.
  - Error: 1 cycle.
- memRead and memWrite are 0 in every state other than RD and WR respectively, and are never high together.
- Load extension:
  - 000 lb and 001 lh sign-extend from bit 7 / bit 15.
  - 010 lw sign-extends from bit 31.
  - 011 ld returns all 64 bits.
  - 100 lbu, 101 lhu and 110 lwu zero-extend.
- Error conditions: load funct3=111; store funct3[2]=1; addr > MEM_BYTES-8 (compared on the full 64-bit address, no wrap). An error produces no memRead and no memWrite, sets resp_err=1 and resp_rdata=0.
- Reset mid-operation: reset returns to IDLE immediately and drops memWrite asynchronously. A store reset while in WR before its edge commits nothing.
- A request offered while the unit is busy sees req_ready=0 and is not sampled.

Optional Feature:
LSU_ALIGN_CHECK_EN
- Defined: an access whose address is not a multiple of its size (half 2, word 4, double 8) is an error, with the same response as the other error conditions.
- Undefined: misaligned accesses are performed normally; the memory is byte-granular.

Test Plan:
Bench preloads memory bytes 0..7 = 56 B1 DE 61 D6 06 52 4C for all scenarios.
- lb addr1 -> resp_rdata=FFFF_FFFF_FFFF_FFB1 two cycles after accept; lbu addr1 -> 0000_0000_0000_00B1.
- ld addr0 -> 4C52_06D6_61DE_B156; lw addr0 -> 0000_0000_61DE_B156; lwu addr4 -> 0000_0000_4C52_06D6.
- sb addr2 wdata=0x...AA -> memRead pulse, then memWrite pulse with mem_write_data for bytes 2..9 with only byte 2 changed, resp 3 cycles after accept; a following ld addr0 -> 4C52_06D6_61AA_B156.
- ld addr57 (MEM_BYTES=64) -> resp_err=1, resp_rdata=0, memRead=memWrite=0 throughout.
- lh addr1 -> with macro: resp_err=1; without macro: FFFF_FFFF_FFFF_DEB1.
- Hold resp_ready=0 for 3 cycles during RESP -> resp_valid and resp_rdata stable, req_ready=0; separately, assert reset in WR of an sd -> memory unchanged, outputs at reset values.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a byte-addressed doubleword memory.
// Optional LSU_ALIGN_CHECK_EN: when defined, misaligned half/word/double accesses are rejected.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        memRead,
  output logic        memWrite,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rd_q, rd_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_err;
  logic [63:0] merged;

  function automatic logic [63:0] load_ext(input logic [2:0] f3, input logic [63:0] d);
    logic [63:0] r;
    case (f3)
      3'b000:  r = {{56{d[7]}}, d[7:0]};
      3'b001:  r = {{48{d[15]}}, d[15:0]};
      3'b010:  r = {{32{d[31]}}, d[31:0]};
      3'b011:  r = d;
      3'b100:  r = {56'd0, d[7:0]};
      3'b101:  r = {48'd0, d[15:0]};
      3'b110:  r = {32'd0, d[31:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Sub-word stores overwrite only the low bytes of the doubleword read back in RD.
  function automatic logic [63:0] store_merge(input logic [1:0] sz, input logic [63:0] old,
                                              input logic [63:0] wd);
    logic [63:0] r;
    case (sz)
      2'b00:   r = {old[63:8], wd[7:0]};
      2'b01:   r = {old[63:16], wd[15:0]};
      2'b10:   r = {old[63:32], wd[31:0]};
      default: r = wd;
    endcase
    return r;
  endfunction

  always_comb begin
    req_err = 1'b0;
    if (req_write) req_err = req_funct3[2];
    else           req_err = (req_funct3 == 3'b111);
    if (req_addr > 64'(MEM_BYTES - 8)) req_err = 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
    case (req_funct3[1:0])
      2'b01:   if (req_addr[0] != 1'b0)    req_err = 1'b1;
      2'b10:   if (req_addr[1:0] != 2'b00) req_err = 1'b1;
      2'b11:   if (req_addr[2:0] != 3'b000) req_err = 1'b1;
      default: ;
    endcase
`endif
  end

  assign merged = store_merge(funct3_q[1:0], rd_q, wdata_q);

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = req_err;
          rdata_d  = '0;
          if (req_err)                      state_d = RESP;
          else if (!req_write)              state_d = RD;
          else if (req_funct3 == 3'b011)    state_d = WR;
          else                              state_d = RD;
        end
      end
      RD: begin
        rd_d = mem_read_data;
        if (write_q) begin
          state_d = WR;
        end else begin
          rdata_d = load_ext(funct3_q, mem_read_data);
          state_d = RESP;
        end
      end
      WR:      state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Outputs decode from state so reset drops memWrite without waiting for an edge.
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = '0;
    resp_err       = 1'b0;
    memRead        = 1'b0;
    memWrite       = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      RD: begin
        memRead     = 1'b1;
        mem_address = addr_q;
      end
      WR: begin
        memWrite       = 1'b1;
        mem_address    = addr_q;
        mem_write_data = merged;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-byte behavioural memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        preload = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        memRead;
  logic        memWrite;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;

  logic [7:0]  mem [64];
  int          total = 0;
  int          bad = 0;
  logic [63:0] held;

  load_store_unit #(.MEM_BYTES(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .memRead(memRead), .memWrite(memWrite),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Bytes 0..7 follow the test plan; the rest hold their own index.
  always @(posedge clk) begin
    if (preload) begin
      mem[0] <= 8'h56; mem[1] <= 8'hB1; mem[2] <= 8'hDE; mem[3] <= 8'h61;
      mem[4] <= 8'hD6; mem[5] <= 8'h06; mem[6] <= 8'h52; mem[7] <= 8'h4C;
      for (int i = 8; i < 64; i++) mem[i] <= 8'(i);
    end else if (memWrite && mem_address <= 64'd56) begin
      for (int i = 0; i < 8; i++) mem[mem_address[5:0] + 6'(i)] <= mem_write_data[8*i +: 8];
    end
  end

  always_comb begin
    mem_read_data = '0;
    if (mem_address <= 64'd56)
      for (int i = 0; i < 8; i++) mem_read_data[8*i +: 8] = mem[mem_address[5:0] + 6'(i)];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, output int lat, output int nrd, output int nwr,
                       output int nboth, output logic [63:0] wseen, output logic [63:0] aseen,
                       output logic [63:0] rdata, output logic err);
    lat = 1; nrd = 0; nwr = 0; nboth = 0; wseen = '0; aseen = '0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    while (!resp_valid && lat < 10) begin
      if (memRead) nrd++;
      if (memWrite) begin nwr++; wseen = mem_write_data; aseen = mem_address; end
      if (memRead && memWrite) nboth++;
      @(negedge clk);
      lat++;
    end
    if (memRead) nrd++;
    if (memWrite) nwr++;
    rdata = resp_rdata;
    err = resp_err;
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic do_ld(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] exp_data, input logic exp_err, input logic wr = 1'b0);
    int lat, nrd, nwr, nboth;
    logic [63:0] ws, as, rd;
    logic er;
    issue(wr, f3, addr, 64'h0, lat, nrd, nwr, nboth, ws, as, rd, er);
    chk({tag, ".lat"}, 64'(lat), exp_err ? 64'd1 : 64'd2);
    chk({tag, ".nrd"}, 64'(nrd), exp_err ? 64'd0 : 64'd1);
    chk({tag, ".nwr"}, 64'(nwr), 64'd0);
    chk({tag, ".rdata"}, rd, exp_data);
    chk({tag, ".err"}, 64'(er), 64'(exp_err));
    release_resp();
  endtask

  task automatic do_st(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] exp_w);
    int lat, nrd, nwr, nboth;
    logic [63:0] ws, as, rd;
    logic er;
    issue(1'b1, f3, addr, wd, lat, nrd, nwr, nboth, ws, as, rd, er);
    chk({tag, ".lat"}, 64'(lat), (f3 == 3'b011) ? 64'd2 : 64'd3);
    chk({tag, ".nrd"}, 64'(nrd), (f3 == 3'b011) ? 64'd0 : 64'd1);
    chk({tag, ".nwr"}, 64'(nwr), 64'd1);
    chk({tag, ".both"}, 64'(nboth), 64'd0);
    chk({tag, ".wdata"}, ws, exp_w);
    chk({tag, ".waddr"}, as, addr);
    chk({tag, ".rdata"}, rd, 64'd0);
    chk({tag, ".err"}, 64'(er), 64'd0);
    release_resp();
  endtask

  initial begin
    @(negedge clk);
    chk("rst.req_ready", 64'(req_ready), 64'd1);
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst.resp_err", 64'(resp_err), 64'd0);
    chk("rst.memRead", 64'(memRead), 64'd0);
    chk("rst.memWrite", 64'(memWrite), 64'd0);
    chk("rst.resp_rdata", resp_rdata, 64'd0);
    chk("rst.mem_address", mem_address, 64'd0);
    chk("rst.mem_write_data", mem_write_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    preload = 1'b0;

    do_ld("lb1",  3'b000, 64'd1, 64'hFFFF_FFFF_FFFF_FFB1, 1'b0);
    do_ld("lbu1", 3'b100, 64'd1, 64'h0000_0000_0000_00B1, 1'b0);
    do_ld("lh0",  3'b001, 64'd0, 64'hFFFF_FFFF_FFFF_B156, 1'b0);
    do_ld("lhu0", 3'b101, 64'd0, 64'h0000_0000_0000_B156, 1'b0);
    do_ld("ld0",  3'b011, 64'd0, 64'h4C52_06D6_61DE_B156, 1'b0);
    do_ld("lw0",  3'b010, 64'd0, 64'h0000_0000_61DE_B156, 1'b0);
    do_ld("lwu4", 3'b110, 64'd4, 64'h0000_0000_4C52_06D6, 1'b0);
`ifdef LSU_ALIGN_CHECK_EN
    do_ld("lh1",  3'b001, 64'd1, 64'h0, 1'b1);
`else
    do_ld("lh1",  3'b001, 64'd1, 64'hFFFF_FFFF_FFFF_DEB1, 1'b0);
`endif
    do_ld("ld56", 3'b011, 64'd56, 64'h3F3E_3D3C_3B3A_3938, 1'b0);
    do_ld("ld57", 3'b011, 64'd57, 64'h0, 1'b1);
    do_ld("ldhuge", 3'b011, 64'h8000_0000_0000_0000, 64'h0, 1'b1);
    do_ld("lf7",  3'b111, 64'd0, 64'h0, 1'b1);
    do_ld("sf4",  3'b100, 64'd0, 64'h0, 1'b1, 1'b1);

    do_st("sb2", 3'b000, 64'd2, 64'h1234_5678_9ABC_DEAA, 64'h0908_4C52_06D6_61AA);
    do_ld("ld0b", 3'b011, 64'd0, 64'h4C52_06D6_61AA_B156, 1'b0);
    do_st("sd16", 3'b011, 64'd16, 64'hA5A5_5A5A_0123_4567, 64'hA5A5_5A5A_0123_4567);
    do_ld("ld16", 3'b011, 64'd16, 64'hA5A5_5A5A_0123_4567, 1'b0);
    do_st("sh40", 3'b001, 64'd40, 64'h1111_2222_3333_BEEF, 64'h2F2E_2D2C_2B2A_BEEF);
    do_ld("ld40", 3'b011, 64'd40, 64'h2F2E_2D2C_2B2A_BEEF, 1'b0);
    do_st("sw48", 3'b010, 64'd48, 64'h4444_5555_CAFE_F00D, 64'h3736_3534_CAFE_F00D);
    do_ld("ld48", 3'b011, 64'd48, 64'h3736_3534_CAFE_F00D, 1'b0);

    begin : hold_test
      int lat, nrd, nwr, nboth;
      logic [63:0] ws, as, rd;
      logic er;
      issue(1'b0, 3'b011, 64'd0, 64'h0, lat, nrd, nwr, nboth, ws, as, rd, er);
      held = rd;
      chk("hold.first", held, 64'h4C52_06D6_61AA_B156);
      for (int k = 0; k < 3; k++) begin
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b011; req_addr = 64'd0;
        req_wdata = '1;
        chk("hold.resp_valid", 64'(resp_valid), 64'd1);
        chk("hold.resp_rdata", resp_rdata, held);
        chk("hold.req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
      end
      req_valid = 1'b0;
      release_resp();
      chk("hold.idle_ready", 64'(req_ready), 64'd1);
      chk("hold.idle_valid", 64'(resp_valid), 64'd0);
      do_ld("hold.ld0", 3'b011, 64'd0, 64'h4C52_06D6_61AA_B156, 1'b0);
    end

    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b011; req_addr = 64'd8;
    req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstwr.inwr", 64'(memWrite), 64'd1);
    reset = 1'b1;
    #1;
    chk("rstwr.memWrite", 64'(memWrite), 64'd0);
    chk("rstwr.req_ready", 64'(req_ready), 64'd1);
    chk("rstwr.resp_valid", 64'(resp_valid), 64'd0);
    chk("rstwr.mem_address", mem_address, 64'd0);
    chk("rstwr.mem_write_data", mem_write_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    do_ld("rstwr.ld8", 3'b011, 64'd8, 64'h0F0E_0D0C_0B0A_0908, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
